// File: rtl/alu_op_sequencer.sv
// Command front-end for the 4-bit combinational ALU: registers operands/select, captures result and accumulator.
// Latency: command accept to res_valid is 2 cycles; one command in flight, so accepts are at least 3 cycles apart.
// Backpressure: cmd_ready is low in EXEC and RESP; the result is held stable while res_ready is low.
module alu_op_sequencer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_use_acc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_sel,
  input  logic [W-1:0]     alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_zero,
  output logic             res_err,
  output logic [W-1:0]     acc,
  output logic [CNT_W-1:0] op_count
);

  // Highest legal select value (XOR); anything above is an illegal opcode.
  localparam logic [2:0] OP_MAX_LEGAL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             cmd_ready_q;
  logic [W-1:0]     alu_a_q;
  logic [W-1:0]     alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             res_valid_q;
  logic [W-1:0]     res_data_q;
  logic             res_zero_q;
  logic             res_err_q;
  logic [W-1:0]     acc_q;
  logic [CNT_W-1:0] op_count_q;

  logic [W-1:0]     alu_a_d;
  logic             op_illegal_d;
  logic [CNT_W-1:0] op_count_d;

  // Operand A source is chosen at the accept edge, so chaining sees the accumulator as it stands then.
  assign alu_a_d      = cmd_use_acc ? acc_q : cmd_a;
  assign op_illegal_d = (alu_sel_q > OP_MAX_LEGAL);
  assign op_count_d   = op_count_q + CNT_W'(1);

  // Sequencer FSM: accept in IDLE, capture ALU result in EXEC, hold result in RESP until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      acc_q       <= '0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= cmd_b;
            alu_sel_q   <= cmd_op;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data_q  <= alu_out;
          res_zero_q  <= (alu_out == '0);
          res_err_q   <= op_illegal_d;
          // Illegal opcodes report an error but leave the accumulator untouched.
          if (!op_illegal_d) begin
            acc_q <= alu_out;
          end
          res_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            op_count_q  <= op_count_d;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_zero  = res_zero_q;
  assign res_err   = res_err_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed test-plan scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level reference model.
// The ALU itself is modelled here as a combinational stub driven by the DUT's registered operands.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic       cmd_use_acc = 1'b0;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_zero;
  logic       res_err;
  logic [3:0] acc;
  logic [7:0] op_count;

  int tests = 0;
  int fails = 0;

  alu_op_sequencer #(.W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_err    (res_err),
    .acc        (acc),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // The 4-bit ALU: ADD/SUB modulo 16, AND, OR, XOR; illegal selects yield 0.
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight. phase 0 = waiting for a command,
  // 1 = command taken (result due next edge), 2 = result offered downstream.
  int         m_phase = 0;
  logic [3:0] m_a = 4'd0;
  logic [3:0] m_b = 4'd0;
  logic [2:0] m_sel = 3'd0;
  logic [3:0] m_res = 4'd0;
  logic       m_zero = 1'b0;
  logic       m_err = 1'b0;
  logic [3:0] m_acc = 4'd0;
  logic [7:0] m_cnt = 8'd0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0;
      m_a = 4'd0; m_b = 4'd0; m_sel = 3'd0;
      m_res = 4'd0; m_zero = 1'b0; m_err = 1'b0;
      m_acc = 4'd0; m_cnt = 8'd0;
    end else if (m_phase == 0) begin
      if (cmd_valid) begin
        m_a = cmd_use_acc ? m_acc : cmd_a;
        m_b = cmd_b;
        m_sel = cmd_op;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_res  = alu_f(m_a, m_b, m_sel);
      m_zero = (m_res == 4'd0);
      m_err  = (m_sel > 3'd4);
      if (!m_err) m_acc = m_res;
      m_phase = 2;
    end else begin
      if (res_ready) begin
        m_cnt = m_cnt + 8'd1;
        m_phase = 0;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
      chk("res_valid", 32'(res_valid), 32'(m_phase == 2));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_sel", 32'(alu_sel), 32'(m_sel));
      chk("res_data", 32'(res_data), 32'(m_res));
      chk("res_zero", 32'(res_zero), 32'(m_zero));
      chk("res_err", 32'(res_err), 32'(m_err));
      chk("acc", 32'(acc), 32'(m_acc));
      chk("op_count", 32'(op_count), 32'(m_cnt));
    end
  end

  // One full transaction from IDLE with literal expectations; entered and left 1ns after a rising edge.
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua,
                        input logic [3:0] exp_alu_a, input logic [3:0] exp_res, input logic exp_zero,
                        input logic exp_err, input logic [3:0] exp_acc, input logic [7:0] exp_cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_use_acc = 1'($urandom);
    chk("lit exec cmd_ready", 32'(cmd_ready), 32'(0));
    chk("lit exec res_valid", 32'(res_valid), 32'(0));
    chk("lit alu_a", 32'(alu_a), 32'(exp_alu_a));
    chk("lit alu_sel", 32'(alu_sel), 32'(op));
    @(posedge clk); #1;
    chk("lit res_valid", 32'(res_valid), 32'(1));
    chk("lit res_data", 32'(res_data), 32'(exp_res));
    chk("lit res_zero", 32'(res_zero), 32'(exp_zero));
    chk("lit res_err", 32'(res_err), 32'(exp_err));
    chk("lit acc", 32'(acc), 32'(exp_acc));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("lit op_count", 32'(op_count), 32'(exp_cnt));
    chk("lit idle cmd_ready", 32'(cmd_ready), 32'(1));
  endtask

  initial begin
    #12;
    chk("rst cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst res_valid", 32'(res_valid), 32'(0));
    chk("rst acc", 32'(acc), 32'(0));
    chk("rst op_count", 32'(op_count), 32'(0));
    chk("rst alu_a", 32'(alu_a), 32'(0));
    chk("rst res_data", 32'(res_data), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // op,  a, b, ua, alu_a, res, zero, err, acc, count
    run_op(3'b000, 4'd3, 4'd5, 1'b0, 4'd3,  4'd8,  1'b0, 1'b0, 4'd8,  8'd1);
    run_op(3'b001, 4'd2, 4'd5, 1'b0, 4'd2,  4'hD,  1'b0, 1'b0, 4'hD,  8'd2);
    run_op(3'b100, 4'd9, 4'd9, 1'b0, 4'd9,  4'd0,  1'b1, 1'b0, 4'd0,  8'd3);
    run_op(3'b000, 4'd7, 4'd4, 1'b0, 4'd7,  4'd11, 1'b0, 1'b0, 4'd11, 8'd4);
    run_op(3'b000, 4'd0, 4'd6, 1'b1, 4'd11, 4'd1,  1'b0, 1'b0, 4'd1,  8'd5);
    run_op(3'b000, 4'd2, 4'd3, 1'b0, 4'd2,  4'd5,  1'b0, 1'b0, 4'd5,  8'd6);
    run_op(3'b110, 4'd1, 4'd1, 1'b0, 4'd1,  4'd0,  1'b1, 1'b1, 4'd5,  8'd7);

    // Backpressure: OR 4|1, res_ready held low 4 cycles with cmd_valid asserted throughout.
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 4'd4; cmd_b = 4'd1; cmd_use_acc = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp cmd_ready", 32'(cmd_ready), 32'(0));
      chk("bp res_valid", 32'(res_valid), 32'(1));
      chk("bp res_data", 32'(res_data), 32'(5));
      chk("bp res_err", 32'(res_err), 32'(0));
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom);
      @(posedge clk); #1;
    end
    cmd_op = 3'b010; cmd_a = 4'hF; cmd_b = 4'd6; cmd_use_acc = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp release op_count", 32'(op_count), 32'(8));
    chk("bp release cmd_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp accept cmd_ready", 32'(cmd_ready), 32'(0));
    @(posedge clk); #1;
    chk("bp and res_data", 32'(res_data), 32'(6));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset asserted while in EXEC discards the operation.
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'd1; cmd_b = 4'd2; cmd_use_acc = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst res_valid", 32'(res_valid), 32'(0));
    chk("midrst acc", 32'(acc), 32'(0));
    chk("midrst op_count", 32'(op_count), 32'(0));
    chk("midrst cmd_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'b000, 4'd1, 4'd1, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0, 4'd2, 8'd1);

    // Long random traffic, no resets, long enough for op_count to wrap.
    for (int i = 0; i < 2000; i++) begin
      cmd_valid   = ($urandom_range(3) != 0);
      cmd_op      = 3'($urandom);
      cmd_a       = 4'($urandom);
      cmd_b       = 4'($urandom);
      cmd_use_acc = 1'($urandom);
      res_ready   = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end
    chk("wrap reached", 32'(m_cnt < 8'd100 ? 1 : 0), 32'(1));

    // Random traffic with occasional asynchronous reset pulses between edges.
    for (int i = 0; i < 400; i++) begin
      cmd_valid   = 1'($urandom);
      cmd_op      = 3'($urandom);
      cmd_a       = 4'($urandom);
      cmd_b       = 4'($urandom);
      cmd_use_acc = 1'($urandom);
      res_ready   = 1'($urandom);
      if ($urandom_range(39) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rnd rst res_valid", 32'(res_valid), 32'(0));
        chk("rnd rst op_count", 32'(op_count), 32'(0));
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end

    cmd_valid = 1'b0;
    res_ready = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
